// File: rtl/acc_frame_sched.sv
// Scheduler for the FIFO-based frame accumulator: arbitrates two requesters and
// sequences LOAD / ADD / DRAIN, driving the datapath strobes, fifo advance and op select.
module acc_frame_sched #(
   parameter int DEPTH = 8,
   parameter int CW    = 3,
   parameter int FCW   = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   input  logic           req0_last,
   input  logic           req1_valid,
   input  logic           req1_last,
   input  logic           dout_ready,
   output logic           req0_ready,
   output logic           req1_ready,
   output logic           sel,
   output logic [1:0]     op,
   output logic           rd_din,
   output logic           rd_fifo,
   output logic           wr_dout,
   output logic           fifo_en,
   output logic           busy,
   output logic           grp_done,
   output logic [FCW-1:0] frame_cnt,
   output logic [1:0]     dbg_state,
   output logic [CW-1:0]  dbg_wcnt
);

   // State codes equal the op encoding so op is a straight copy of the state.
   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_ADD   = 2'd1,
      S_DRAIN = 2'd2,
      S_IDLE  = 2'd3
   } state_t;

   localparam logic [CW-1:0]  LAST_W = CW'(DEPTH - 1);
   localparam logic [FCW-1:0] FC_MAX = {FCW{1'b1}};

   state_t         state, state_n;
   logic [CW-1:0]  wcnt, wcnt_n;
   logic [FCW-1:0] fc_n;
   logic           sel_n, last_grant, last_grant_n, done_n;
   logic           gvalid, glast, xfer, word_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         wcnt       <= '0;
         frame_cnt  <= '0;
         grp_done   <= 1'b0;
         sel        <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_n;
         wcnt       <= wcnt_n;
         frame_cnt  <= fc_n;
         grp_done   <= done_n;
         sel        <= sel_n;
         last_grant <= last_grant_n;
      end
   end

   // Handshake: a word moves (xfer) in any cycle where the granted requester's valid
   // is high in LOAD/ADD, or dout_ready is high in DRAIN; the matching ready/strobes
   // are asserted combinationally in that same cycle and never otherwise.
   always_comb begin
      gvalid   = sel ? req1_valid : req0_valid;
      glast    = sel ? req1_last : req0_last;
      word_end = (wcnt == LAST_W);
      xfer     = 1'b0;
      case (state)
         S_LOAD, S_ADD: xfer = gvalid;
         S_DRAIN:       xfer = dout_ready;
         default:       xfer = 1'b0;
      endcase
   end

   always_comb begin
      state_n      = state;
      wcnt_n       = wcnt;
      fc_n         = frame_cnt;
      sel_n        = sel;
      last_grant_n = last_grant;
      done_n       = 1'b0;
      case (state)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               sel_n   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
               state_n = S_LOAD;
               wcnt_n  = '0;
               fc_n    = '0;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               wcnt_n = wcnt + CW'(1);
               if (word_end) begin
                  fc_n    = FCW'(1);
                  state_n = glast ? S_DRAIN : S_ADD;
               end
            end
         end
         S_ADD: begin
            if (xfer) begin
               wcnt_n = wcnt + CW'(1);
               if (word_end) begin
                  if (frame_cnt != FC_MAX) fc_n = frame_cnt + FCW'(1);
                  state_n = glast ? S_DRAIN : S_ADD;
               end
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               wcnt_n = wcnt + CW'(1);
               if (word_end) begin
                  state_n      = S_IDLE;
                  last_grant_n = sel;
                  done_n       = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign op         = state;
   assign busy       = (state != S_IDLE);
   assign fifo_en    = xfer;
   assign rd_fifo    = xfer;
   assign rd_din     = xfer && (state == S_LOAD || state == S_ADD);
   assign req0_ready = rd_din && !sel;
   assign req1_ready = rd_din && sel;
   assign wr_dout    = xfer && (state == S_DRAIN);
   assign dbg_state  = state;
   assign dbg_wcnt   = wcnt;

endmodule

// File: tb/tb_acc_frame_sched.sv
// Directed bench for acc_frame_sched: a group-level model predicts every output each
// cycle, and literal per-test totals pin the model to hand-computed values.
module tb_acc_frame_sched;
   localparam int DEPTH = 8;
   localparam int CW    = 3;
   localparam int FCW   = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
   logic dout_ready = 1'b1;
   logic req0_ready, req1_ready, sel, rd_din, rd_fifo, wr_dout, fifo_en, busy, grp_done;
   logic [1:0] op, dbg_state;
   logic [FCW-1:0] frame_cnt;
   logic [CW-1:0] dbg_wcnt;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   acc_frame_sched #(.DEPTH(DEPTH), .CW(CW), .FCW(FCW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_last(req0_last),
      .req1_valid(req1_valid), .req1_last(req1_last),
      .dout_ready(dout_ready),
      .req0_ready(req0_ready), .req1_ready(req1_ready), .sel(sel), .op(op),
      .rd_din(rd_din), .rd_fifo(rd_fifo), .wr_dout(wr_dout), .fifo_en(fifo_en),
      .busy(busy), .grp_done(grp_done), .frame_cnt(frame_cnt),
      .dbg_state(dbg_state), .dbg_wcnt(dbg_wcnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Group view: idle, or owned by one requester; word position in the current
   // frame, number of completed frames, and whether the result is being drained.
   bit m_busy = 0, m_owner = 0, m_last_owner = 1, m_drain = 0, m_done = 0;
   int m_word = 0, m_frames = 0;

   function automatic bit m_xfer();
      if (!m_busy) return 1'b0;
      if (m_drain) return dout_ready;
      return m_owner ? req1_valid : req0_valid;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_owner = 0; m_last_owner = 1; m_drain = 0; m_done = 0;
         m_word = 0; m_frames = 0;
      end else begin
         bit x, lst;
         x   = m_xfer();
         lst = m_owner ? req1_last : req0_last;
         m_done = 0;
         if (!m_busy) begin
            if (req0_valid || req1_valid) begin
               m_owner  = (req0_valid && req1_valid) ? !m_last_owner : req1_valid;
               m_busy   = 1; m_word = 0; m_frames = 0; m_drain = 0;
            end
         end else if (x) begin
            if (m_word == DEPTH - 1) begin
               m_word = 0;
               if (m_drain) begin
                  m_busy = 0; m_drain = 0; m_last_owner = m_owner; m_done = 1;
               end else begin
                  m_frames++;
                  if (lst) m_drain = 1;
               end
            end else begin
               m_word++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [23:0] act_v, exp_v;
      logic [1:0]  e_op;
      bit          x, rdd;
      int          fc;
      e_op  = !m_busy ? 2'd3 : m_drain ? 2'd2 : (m_frames == 0) ? 2'd0 : 2'd1;
      x     = m_xfer();
      rdd   = x && !m_drain;
      fc    = (m_frames > 255) ? 255 : m_frames;
      exp_v = {e_op, e_op, m_owner, rdd, x, x && m_drain, x, m_busy, m_done,
               rdd && !m_owner, rdd && m_owner, FCW'(fc), CW'(m_word)};
      act_v = {op, dbg_state, sel, rd_din, rd_fifo, wr_dout, fifo_en, busy, grp_done,
               req0_ready, req1_ready, frame_cnt, dbg_wcnt};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL cycle_outputs: got %h expected %h (t=%0t)", act_v, exp_v, $time);
      end
   end

   // ---------------- monitor totals ----------------
   int tot_busy = 0, tot_rd_load = 0, tot_rd_add = 0, tot_rd = 0, tot_wr = 0;
   int tot_drain = 0, tot_r1 = 0, tot_done = 0, fc_at_done = -1;
   logic [0:0] grant_q[$];

   always @(negedge clk) begin
      if (busy) tot_busy++;
      if (rd_din && op == 2'd0) tot_rd_load++;
      if (rd_din && op == 2'd1) tot_rd_add++;
      if (rd_din) tot_rd++;
      if (wr_dout) tot_wr++;
      if (op == 2'd2) tot_drain++;
      if (req1_ready) tot_r1++;
      if (grp_done) begin
         tot_done++;
         fc_at_done = int'(frame_cnt);
      end
      if (rd_din && op == 2'd0 && dbg_wcnt == '0) grant_q.push_back(sel);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_valid(input bit who, input bit v);
      if (who) req1_valid = v; else req0_valid = v;
   endtask

   task automatic set_last(input bit who, input bit v);
      if (who) req1_last = v; else req0_last = v;
   endtask

   // Offer `total` words from one requester; last rides on the final word and
   // optionally on word fake_at; valid drops for gap_len cycles at word gap_at.
   task automatic feed(input bit who, input int total, input int gap_at,
                       input int gap_len, input int fake_at);
      int k = 0, g = 0, t = 0;
      while (k < total && t < total * 3 + 100) begin
         bit in_gap;
         in_gap = (gap_at >= 0 && k == gap_at && g < gap_len);
         if (in_gap) g++;
         set_valid(who, !in_gap);
         set_last(who, (k == total - 1) || (k == fake_at));
         @(negedge clk);
         if (who ? req1_ready : req0_ready) k++;
         tick();
         t++;
      end
      set_valid(who, 1'b0);
      set_last(who, 1'b0);
      chk("feed_words", k, total);
   endtask

   // Run the drain to IDLE, optionally holding dout_ready low at drain word stall_at.
   task automatic drain(input int stall_at, input int stall_len);
      int n = 0, s = 0, t = 0;
      bit idle_seen = 0;
      while (t < 200) begin
         dout_ready = !(stall_at >= 0 && n == stall_at && s < stall_len);
         if (!dout_ready) s++;
         @(negedge clk);
         if (wr_dout) n++;
         if (!busy) begin
            idle_seen = 1;
            break;
         end
         tick();
         t++;
      end
      dout_ready = 1'b1;
      tick();
      chk("drain_words", n, DEPTH);
      chk("drain_reached_idle", int'(idle_seen), 1);
   endtask

   task automatic wait_words(input bit who, input int n);
      int k = 0, t = 0;
      while (k < n && t < n * 3 + 50) begin
         @(negedge clk);
         if (who ? req1_ready : req0_ready) k++;
         tick();
         t++;
      end
      chk("wait_words", k, n);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   logic [0:0] exp_q[$];

   initial begin
      int b_busy, b_load, b_add, b_wr, b_done, b_drain, b_r1, b_rd, gb;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_op", int'(op), 3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      tick();
      reset = 1'b1;

      // 1: reset dropped mid-LOAD takes effect in the same cycle
      req1_valid = 1'b1;
      wait_words(1'b1, 4);
      reset = 1'b0;
      #1;
      chk("t1_op", int'(op), 3);
      chk("t1_busy", int'(busy), 0);
      chk("t1_strobes", int'({rd_din, rd_fifo, wr_dout, fifo_en, req0_ready, req1_ready}), 0);
      chk("t1_frame_cnt", int'(frame_cnt), 0);
      req1_valid = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t1_idle_op", int'(op), 3);
      chk("t1_idle_busy", int'(busy), 0);

      // 2: req0 alone, three frames, no stalls
      b_busy = tot_busy; b_load = tot_rd_load; b_add = tot_rd_add; b_wr = tot_wr; b_done = tot_done;
      feed(1'b0, 3 * DEPTH, -1, 0, -1);
      drain(-1, 0);
      chk("t2_load_words", tot_rd_load - b_load, 8);
      chk("t2_add_words", tot_rd_add - b_add, 16);
      chk("t2_drain_words", tot_wr - b_wr, 8);
      chk("t2_grp_done", tot_done - b_done, 1);
      chk("t2_fc_at_done", fc_at_done, 3);
      chk("t2_busy_cycles", tot_busy - b_busy, 32);
      chk("t2_fc_held", int'(frame_cnt), 3);

      // 3: both valid from reset -> req0, req1, req0
      tick();
      reset = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
      reset = 1'b1;
      b_r1 = tot_r1;
      gb = grant_q.size();
      exp_q = {1'b0, 1'b1, 1'b0};
      feed(1'b0, DEPTH, -1, 0, -1);
      req0_valid = 1'b1;
      chk("t3_req1_ready_while_req0", tot_r1 - b_r1, 0);
      drain(-1, 0);
      feed(1'b1, DEPTH, -1, 0, -1);
      req1_valid = 1'b1;
      drain(-1, 0);
      feed(1'b0, DEPTH, -1, 0, -1);
      req1_valid = 1'b0;
      drain(-1, 0);
      chk("t3_grants", grant_q.size() - gb, 3);
      for (int i = 0; i < 3; i++)
         if (gb + i < grant_q.size())
            chk($sformatf("t3_grant%0d", i), int'(grant_q[gb + i]), int'(exp_q[i]));

      // 4: dout_ready low for 5 cycles at drain word 3
      b_wr = tot_wr; b_drain = tot_drain;
      feed(1'b0, DEPTH, -1, 0, -1);
      drain(3, 5);
      chk("t4_wr_pulses", tot_wr - b_wr, 8);
      chk("t4_drain_cycles", tot_drain - b_drain, 13);

      // 5: valid gap at frame-2 word 3, stray last at word 4 is ignored
      b_rd = tot_rd; b_add = tot_rd_add;
      feed(1'b0, 3 * DEPTH, DEPTH + 3, 2, DEPTH + 4);
      drain(-1, 0);
      chk("t5_words", tot_rd - b_rd, 24);
      chk("t5_add_words", tot_rd_add - b_add, 16);
      chk("t5_fc_at_done", fc_at_done, 3);

      // 6: reset during ADD frame 2 word 5, then req1 starts fresh
      req0_valid = 1'b1;
      wait_words(1'b0, DEPTH + 5);
      chk("t6_pre_op", int'(op), 1);
      chk("t6_pre_wcnt", int'(dbg_wcnt), 5);
      reset = 1'b0;
      #1;
      chk("t6_op", int'(op), 3);
      chk("t6_busy", int'(busy), 0);
      chk("t6_frame_cnt", int'(frame_cnt), 0);
      chk("t6_req0_ready", int'(req0_ready), 0);
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      chk("t6_load_op", int'(op), 0);
      chk("t6_sel", int'(sel), 1);
      chk("t6_wcnt", int'(dbg_wcnt), 0);
      feed(1'b1, DEPTH, -1, 0, -1);
      drain(-1, 0);
      chk("t6_fc_at_done", fc_at_done, 1);

      // 7: frame counter saturates at 255
      feed(1'b0, 260 * DEPTH, -1, 0, -1);
      drain(-1, 0);
      chk("t7_fc_saturated", fc_at_done, 255);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
